// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM period/duty meter: FSM state encoding and
// the default measurement counter width.
package pwm_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        TIMEOUT = 2'd2
    } state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic r_s1;
    logic r_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= d;
            r_s2 <= r_s1;
        end
    end

    assign q = r_s2;

endmodule

// File: rtl/pwm_meter.sv
// PWM meter: measures period (reported as period-1) and high time between
// successive rising edges of pwm_in, with a sticky timeout for stalled input.
module pwm_meter
    import pwm_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             pwm_in,
    output logic [WIDTH-1:0] wave_length,
    output logic [WIDTH-1:0] high_time,
    output logic             valid,
    output logic             timeout,
    output logic             level
);

    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_LAST = CNT_MAX - CNT_ONE;

    logic             w_s2;
    logic             w_rise;
    logic             r_s3;
    state_t           r_state;
    logic [WIDTH-1:0] r_cnt_p;
    logic [WIDTH-1:0] r_cnt_h;
    logic [WIDTH-1:0] r_wave_length;
    logic [WIDTH-1:0] r_high_time;
    logic             r_valid;
    logic             r_timeout;

    sync2 u_sync2 (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pwm_in),
        .q     (w_s2)
    );

    assign w_rise = w_s2 & ~r_s3;

    // The rise cycle itself counts as the first high cycle, hence cnt_h restarts at 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s3          <= 1'b0;
            r_state       <= IDLE;
            r_cnt_p       <= '0;
            r_cnt_h       <= '0;
            r_wave_length <= '0;
            r_high_time   <= '0;
            r_valid       <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_s3    <= w_s2;
            r_valid <= 1'b0;
            if (!enable) begin
                r_state <= IDLE;
                r_cnt_p <= '0;
                r_cnt_h <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_rise) begin
                            r_state <= MEASURE;
                            r_cnt_p <= '0;
                            r_cnt_h <= CNT_ONE;
                        end else if (r_cnt_p == CNT_LAST) begin
                            r_cnt_p   <= CNT_MAX;
                            r_timeout <= 1'b1;
                            r_state   <= TIMEOUT;
                        end else begin
                            r_cnt_p <= r_cnt_p + CNT_ONE;
                        end
                    end
                    MEASURE: begin
                        if (w_rise) begin
                            r_wave_length <= r_cnt_p;
                            r_high_time   <= r_cnt_h;
                            r_valid       <= 1'b1;
                            r_timeout     <= 1'b0;
                            r_cnt_p       <= '0;
                            r_cnt_h       <= CNT_ONE;
                        end else begin
                            if (r_cnt_p == CNT_LAST) begin
                                r_cnt_p   <= CNT_MAX;
                                r_timeout <= 1'b1;
                                r_state   <= TIMEOUT;
                            end else begin
                                r_cnt_p <= r_cnt_p + CNT_ONE;
                            end
                            if (w_s2 && (r_cnt_h != CNT_MAX)) begin
                                r_cnt_h <= r_cnt_h + CNT_ONE;
                            end
                        end
                    end
                    TIMEOUT: begin
                        // Timeout stays asserted until a full period produces a result.
                        if (w_rise) begin
                            r_state <= MEASURE;
                            r_cnt_p <= '0;
                            r_cnt_h <= CNT_ONE;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_cnt_p <= '0;
                        r_cnt_h <= '0;
                    end
                endcase
            end
        end
    end

    assign wave_length = r_wave_length;
    assign high_time   = r_high_time;
    assign valid       = r_valid;
    assign timeout     = r_timeout;
    assign level       = w_s2;

endmodule

// File: doc/pwm_meter.md
PWM_METER -- requirements
Module: pwm_meter

Interface
REQ-001 Parameter WIDTH, default 16: width of the measurement counters and result outputs.
REQ-002 clk  input  1  single clock for all logic.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 enable  input  1  measurement enable; low holds the block idle.
REQ-005 pwm_in  input  1  PWM waveform, asynchronous to clk.
REQ-006 wave_length  output  WIDTH  last measured period minus 1, in clk cycles.
REQ-007 high_time  output  WIDTH  last measured high duration, in clk cycles.
REQ-008 valid  output  1  one-cycle pulse when wave_length/high_time update.
REQ-009 timeout  output  1  sticky flag: no rising edge within 2^WIDTH-1 cycles.
REQ-010 level  output  1  synchronized pwm_in level (stuck level when timeout=1).

Function
REQ-011 pwm_in SHALL pass a 2-flop synchronizer (s1->s2), then a third flop s3; rise = s2 & ~s3.
REQ-012 State machine SHALL have states IDLE (awaiting first rise), MEASURE (counting), and TIMEOUT (no edges).
REQ-013 IDLE->MEASURE on rise; cnt_p<=0, cnt_h<=1; no valid.
REQ-014 In MEASURE, each non-rise cycle: cnt_p+1; cnt_h+1 when s2=1.
REQ-015 In MEASURE on rise: wave_length<=cnt_p, high_time<=cnt_h, valid<=1, timeout<=0; cnt_p<=0, cnt_h<=1; stay in MEASURE.
REQ-016 Convention: period P cycles, H high cycles -> wave_length=P-1, high_time=H (matches the pwd generator inputs).
REQ-017 Latency: valid SHALL be high in the cycle after the third clk edge, counting the edge that first samples pwm_in=1 as the first.
REQ-018 Counters SHALL saturate, never wrap; cnt_p reaching 2^WIDTH-1 in MEASURE or IDLE SHALL set timeout=1 and go to TIMEOUT.
REQ-019 In TIMEOUT: outputs wave_length/high_time SHALL hold; a rise SHALL restart as IDLE->MEASURE (REQ-013), with timeout cleared only on the next valid.
REQ-020 A rise in IDLE SHALL NOT produce valid; the first result requires two rises.
REQ-021 enable=0 SHALL force IDLE and zero the counters within one cycle; results and timeout hold; no valid while enable=0.
REQ-022 A falling edge with no subsequent rise SHALL NOT update results.
REQ-023 Constant-low input (duty 0) and constant-high input (duty 100%) SHALL both end in TIMEOUT, with level = 0 or 1 respectively.

Reset
REQ-024 rst_n=0 SHALL asynchronously set: state IDLE, s1/s2/s3=0, counters 0, wave_length=0, high_time=0, valid=0, timeout=0, level=0.
REQ-025 Reset mid-measurement SHALL discard the partial period; a full two-rise cycle is required after release before valid.

Structure
REQ-026 Shared package pwm_pkg SHALL hold the state enum (IDLE, MEASURE, TIMEOUT) and the default WIDTH constant.
REQ-027 The synchronizer SHALL be a sub-module sync2 (2 flops, async active-low reset, reset value 0).
REQ-028 All other logic SHALL live in pwm_meter.

Verification
REQ-029 pwd stimulus wave_length=9, high_time=3 -> valid every 10 cycles, wave_length=9, high_time=3; the first valid follows the second rise.
REQ-030 Change the stimulus to wave_length=4, high_time=4 -> after one transitional period, each valid reports 4/4 every 5 cycles (wave_length=4, high_time=4).
REQ-031 WIDTH=8, pwm_in held 0 -> timeout=1 at cycle 255 after the last rise, level=0; a restarted period 10/high 3 -> valid with 9/3, timeout=0.
REQ-032 WIDTH=8, pwm_in held 1 -> timeout=1, level=1, no valid.
REQ-033 rst_n pulsed low mid-period -> all outputs 0 immediately; no valid until two rises after release.
REQ-034 enable=0 for 7 cycles mid-stream -> no valid, results held; after re-enable, the first valid arrives after two rises with the correct values.
